// File: rtl/bijiao_pkg.sv
// Shared constants and state encoding for the time-shared comparator sorter.
package bijiao_pkg;
    localparam int DEF_W = 4;
    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/bijiao_cell.sv
// Unsigned W-bit magnitude comparator; exactly one of xgy/xsy/xey is high.
module bijiao_cell #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         xgy,
    output logic         xsy,
    output logic         xey
);
    assign xgy = (x > y);
    assign xsy = (x < y);
    assign xey = (x == y);
endmodule

// File: rtl/bijiao_paixu_ctrl.sv
// Loads an N-word frame, bubble-sorts it in place with one shared comparator
// (one compare per cycle), then streams the sorted frame out.
module bijiao_paixu_ctrl
    import bijiao_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         desc,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_I = IW'(N - 2);
    localparam logic [IW-1:0] LAST_W = IW'(N - 1);

    state_t                r_state;
    logic [IW-1:0]         r_wr, r_i, r_rd, r_pass;
    logic                  r_swapped, r_desc;
    logic [N-1:0][W-1:0]   r_buf;

    logic [IW-1:0] w_i1;
    logic [W-1:0]  w_x, w_y;
    logic          w_xgy, w_xsy, w_xey, w_swap;

    assign w_i1 = r_i + 1'b1;
    assign w_x  = r_buf[r_i];
    assign w_y  = r_buf[w_i1];

    bijiao_cell #(.W(W)) u_cell (
        .x   (w_x),
        .y   (w_y),
        .xgy (w_xgy),
        .xsy (w_xsy),
        .xey (w_xey)
    );

    // Equal words never swap, which keeps the sort stable.
    assign w_swap = !w_xey && (r_desc ? w_xsy : w_xgy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_wr      <= '0;
            r_i       <= '0;
            r_rd      <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
            r_desc    <= 1'b0;
            r_buf     <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r_buf[r_wr] <= in_data;
                        if (r_wr == '0) r_desc <= desc;
                        if (r_wr == LAST_W) begin
                            r_state   <= ST_SORT;
                            r_i       <= '0;
                            r_swapped <= 1'b0;
                            r_pass    <= '0;
                        end else begin
                            r_wr <= r_wr + 1'b1;
                        end
                    end
                end
                ST_SORT: begin
                    if (w_swap) begin
                        r_buf[r_i]  <= w_y;
                        r_buf[w_i1] <= w_x;
                    end
                    if (r_i != LAST_I) begin
                        r_i <= w_i1;
                        if (w_swap) r_swapped <= 1'b1;
                    end else if ((r_swapped || w_swap) && (r_pass != LAST_I)) begin
                        // Pass index N-2 is the (N-1)th pass; bubble sort is done by then.
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                        r_pass    <= r_pass + 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                        r_rd    <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_rd == LAST_W) begin
                            r_state <= ST_LOAD;
                            r_wr    <= '0;
                        end else begin
                            r_rd <= r_rd + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_LOAD);
    assign out_valid = (r_state == ST_DRAIN);
    assign out_data  = r_buf[r_rd];
    assign out_last  = (r_state == ST_DRAIN) && (r_rd == LAST_W);
endmodule

// File: tb/tb_bijiao_paixu_ctrl.sv
// Directed scoreboard bench for bijiao_paixu_ctrl (W=4, N=4).
module tb_bijiao_paixu_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       desc;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    bijiao_paixu_ctrl #(.W(4), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .desc      (desc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; desc differs on words 2..4 so only first-word sampling works.
    task automatic send(input logic [3:0] a, b, c, d, input logic dsc, input bit junk);
        logic [3:0] w[4];
        w = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = w[k];
            desc     = (k == 0) ? dsc : ~dsc;
            chk("in_ready_load", in_ready, 1);
            step;
        end
        in_valid = junk;
        in_data  = 4'($urandom);
        chk("busy_after_load", busy, 1);
        chk("in_ready_sort", in_ready, 0);
    endtask

    task automatic sort_wait(input int exp_cycles, input bit junk);
        int n = 0;
        while (!out_valid && n < 200) begin
            if (junk) in_data = 4'($urandom);
            n++;
            step;
        end
        chk("sort_cycles", n, exp_cycles);
    endtask

    task automatic drain(input int stall_at, input bit junk);
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
                e = 'x;
            end else begin
                e = exp_q.pop_front();
            end
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    if (junk) in_data = 4'($urandom);
                    step;
                    chk("stall_data", out_data, e);
                    chk("stall_valid", out_valid, 1);
                end
            end
            out_ready = 1'b1;
            if (junk) in_data = 4'($urandom);
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, e);
            chk("out_last", out_last, (k == 3) ? 1 : 0);
            step;
        end
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    task automatic push4(input logic [3:0] a, b, c, d);
        exp_q.push_back(a); exp_q.push_back(b);
        exp_q.push_back(c); exp_q.push_back(d);
    endtask

    initial begin
        rst = 1'b1; desc = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        step;
        rst = 1'b0;
        step;

        // 1: basic ascending
        push4(0, 1, 2, 3);
        send(3, 1, 2, 0, 1'b0, 1'b0);
        sort_wait(9, 1'b0);
        drain(-1, 1'b0);

        // 2: already sorted -> single pass
        push4(1, 2, 3, 4);
        send(1, 2, 3, 4, 1'b0, 1'b0);
        sort_wait(3, 1'b0);
        drain(-1, 1'b0);

        // 3: descending with equal pair; an equal swap would force a third pass
        push4(4'hF, 4'h8, 4'h8, 4'h0);
        send(4'hF, 4'h0, 4'h8, 4'h8, 1'b1, 1'b0);
        sort_wait(6, 1'b0);
        drain(-1, 1'b0);

        // 4: reversed, worst case, stall mid-drain
        push4(0, 1, 2, 3);
        send(3, 2, 1, 0, 1'b0, 1'b0);
        sort_wait(9, 1'b0);
        drain(1, 1'b0);

        // 5: reset mid-sort abandons frame
        push4(0, 1, 2, 3);
        send(2, 3, 1, 0, 1'b0, 1'b0);
        step;
        step;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        step;
        rst = 1'b0;
        step;
        chk("midrst_idle_valid", out_valid, 0);
        push4(4, 5, 6, 7);
        send(5, 4, 7, 6, 1'b0, 1'b0);
        sort_wait(6, 1'b0);
        drain(-1, 1'b0);

        // 6: junk on input during SORT/DRAIN, back-to-back frames
        push4(4'hE, 4'h9, 4'h7, 4'h1);
        send(4'h9, 4'hE, 4'h1, 4'h7, 1'b1, 1'b1);
        sort_wait(6, 1'b1);
        drain(2, 1'b1);
        push4(4'h2, 4'h6, 4'h6, 4'hB);
        send(4'h6, 4'h6, 4'h2, 4'hB, 1'b0, 1'b1);
        sort_wait(9, 1'b1);
        drain(-1, 1'b1);
        in_valid = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
